proc_control_unit: RTL

Multi-cycle control FSM for the processor datapath: holds the instruction register and sequences fetch, decode and execute for each 16-bit instruction. Drives the PC, data memory, register file and ALU, including the select of the register-file write-data 2-to-1 mux (ALU result vs. data-memory read data). Sits between instruction memory and the datapath; one instance per processor.

---
 rtl/proc_control_unit_if.sv | 36 +++
 rtl/proc_control_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/proc_control_unit_if.sv
// Control-unit to datapath bundle: instruction fetch data in,
// PC / data-memory / register-file / ALU controls out.
interface proc_control_unit_if;
    logic [15:0] ir_in;
    logic        pc_clr;
    logic        pc_up;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_wr;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s;
    logic        halted;
    logic [3:0]  state_out;

    modport master (
        input  ir_in,
        output pc_clr, pc_up, ir_ld,
        output d_addr, d_wr, rf_s,
        output rf_w_addr, rf_w_wr,
        output rf_ra_addr, rf_rb_addr,
        output alu_s, halted, state_out
    );

    modport slave (
        output ir_in,
        input  pc_clr, pc_up, ir_ld,
        input  d_addr, d_wr, rf_s,
        input  rf_w_addr, rf_w_wr,
        input  rf_ra_addr, rf_rb_addr,
        input  alu_s, halted, state_out
    );
endinterface

// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/decode/execute control FSM with instruction
// register; Moore strobes plus combinational IR field decode.
module proc_control_unit #(
    parameter int         IW      = 16,
    parameter logic [2:0] ALU_ADD = 3'd1,
    parameter logic [2:0] ALU_SUB = 3'd2
) (
    input  logic                clk,
    input  logic                reset_n,
    proc_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] ir;
    logic [3:0]    op;
    logic          ld;

    assign op = ir[IW-1:IW-4];

    // State and instruction register; reset clears both at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (ld) begin
                ir <= bus.ir_in;
            end
        end
    end

    // Next-state selection and Moore strobes for the current state
    always_comb begin
        state_nx   = S_INIT;
        ld         = 1'b0;
        bus.pc_clr = 1'b0;
        bus.pc_up  = 1'b0;
        bus.d_wr   = 1'b0;
        bus.rf_s   = 1'b0;
        bus.rf_w_wr = 1'b0;
        bus.alu_s  = 3'd0;
        bus.halted = 1'b0;
        unique case (state)
            S_INIT: begin
                bus.pc_clr = 1'b1;
                state_nx   = S_FETCH;
            end
            S_FETCH: begin
                ld        = 1'b1;
                bus.pc_up = 1'b1;
                state_nx  = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_STORE: state_nx = S_STORE;
                    OP_LOAD:  state_nx = S_LOAD_A;
                    OP_ADD:   state_nx = S_ADD;
                    OP_SUB:   state_nx = S_SUB;
                    OP_HALT:  state_nx = S_HALT;
                    default:  state_nx = S_NOOP;
                endcase
            end
            S_NOOP: begin
                state_nx = S_FETCH;
            end
            S_LOAD_A: begin
                bus.rf_s = 1'b1;
                state_nx = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.rf_s    = 1'b1;
                bus.rf_w_wr = 1'b1;
                state_nx    = S_FETCH;
            end
            S_STORE: begin
                bus.d_wr = 1'b1;
                state_nx = S_FETCH;
            end
            S_ADD: begin
                bus.alu_s   = ALU_ADD;
                bus.rf_w_wr = 1'b1;
                state_nx    = S_FETCH;
            end
            S_SUB: begin
                bus.alu_s   = ALU_SUB;
                bus.rf_w_wr = 1'b1;
                state_nx    = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                state_nx   = S_HALT;
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    // Operand/address fields straight from IR, stable through execute
    always_comb begin
        bus.d_addr     = 8'h00;
        bus.rf_w_addr  = 4'h0;
        bus.rf_ra_addr = 4'h0;
        bus.rf_rb_addr = 4'h0;
        case (op)
            OP_LOAD: begin
                bus.d_addr    = ir[11:4];
                bus.rf_w_addr = ir[3:0];
            end
            OP_STORE: begin
                bus.d_addr     = ir[7:0];
                bus.rf_ra_addr = ir[11:8];
            end
            OP_ADD, OP_SUB: begin
                bus.rf_ra_addr = ir[11:8];
                bus.rf_rb_addr = ir[7:4];
                bus.rf_w_addr  = ir[3:0];
            end
            default: begin
                bus.d_addr = 8'h00;
            end
        endcase
    end

    assign bus.ir_ld     = ld;
    assign bus.state_out = state;

endmodule
